// File: rtl/tof_meas_ctrl_pkg.sv
// rtl/tof_meas_ctrl_pkg.sv - shared types and constants for the time-of-flight sequencer
package tof_pkg;

  localparam int FINE_W_DEF  = 13;
  localparam int COARSE_W_DEF = 8;
  localparam int MEAS_ID_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_FIRE   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_STOP   = 3'd4,
    ST_SETTLE = 3'd5,
    ST_HOLD   = 3'd6
  } tof_state_e;

endpackage

// File: rtl/tof_meas_ctrl_if.sv
// rtl/tof_meas_ctrl_if.sv - result handshake bundle between sequencer and downstream consumer
interface tof_meas_ctrl_if
  import tof_pkg::*;
#(
  parameter int FINE_W   = FINE_W_DEF,
  parameter int COARSE_W = COARSE_W_DEF
) ();

  logic                 result_valid;
  logic                 result_ready;
  logic [FINE_W-1:0]    result_fine;
  logic [COARSE_W-1:0]  result_coarse;
  logic                 result_timeout;
  logic [MEAS_ID_W-1:0] meas_id;

  modport master (
    output result_valid, result_fine, result_coarse, result_timeout, meas_id,
    input  result_ready
  );

  modport slave (
    input  result_valid, result_fine, result_coarse, result_timeout, meas_id,
    output result_ready
  );

endinterface

// File: rtl/tof_meas_ctrl_echo_edge_det.sv
// rtl/tof_meas_ctrl_echo_edge_det.sv - registered echo history with combinational rising-edge flag
module echo_edge_det (
  input  logic clk,
  input  logic reset_n,
  input  logic echo,
  output logic rise
);

  logic echo_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      echo_d <= 1'b0;
    end else begin
      echo_d <= echo;
    end
  end

  assign rise = echo & ~echo_d;

endmodule

// File: rtl/tof_meas_ctrl.sv
// rtl/tof_meas_ctrl.sv - measurement sequencer: clear, fire, wait for echo or timeout, present counts
module tof_meas_ctrl
  import tof_pkg::*;
#(
  parameter int FINE_W         = FINE_W_DEF,
  parameter int COARSE_W       = COARSE_W_DEF,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_COARSE = 200
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                meas_req,
  input  logic                echo,
  input  logic [FINE_W-1:0]   fine_cnt,
  input  logic [COARSE_W-1:0] coarse_cnt,
  output logic                cntr_reset,
  output logic                cntr_start,
  output logic                cntr_stop,
  output logic                laser_fire,
  output logic                busy,
  tof_meas_ctrl_if.master     res
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_CLR    = ST_CLR;
  localparam logic [2:0] S_FIRE   = ST_FIRE;
  localparam logic [2:0] S_WAIT   = ST_WAIT;
  localparam logic [2:0] S_STOP   = ST_STOP;
  localparam logic [2:0] S_SETTLE = ST_SETTLE;
  localparam logic [2:0] S_HOLD   = ST_HOLD;

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [RC_W-1:0] rst_cnt;
  logic            to_flag;
  logic            rise;
  logic            timeout_hit;

  echo_edge_det u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .echo    (echo),
    .rise    (rise)
  );

  assign timeout_hit = (coarse_cnt >= COARSE_W'(TIMEOUT_COARSE));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (meas_req) state_nxt = S_CLR;
      S_CLR:    if (rst_cnt == '0) state_nxt = S_FIRE;
      S_FIRE:   state_nxt = S_WAIT;
      S_WAIT:   if (rise || timeout_hit) state_nxt = S_STOP;
      S_STOP:   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_HOLD;
      S_HOLD:   if (res.result_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode the next state so every strobe is registered yet lands in its own cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_IDLE;
      rst_cnt            <= '0;
      to_flag            <= 1'b0;
      cntr_reset         <= 1'b0;
      cntr_start         <= 1'b0;
      cntr_stop          <= 1'b0;
      laser_fire         <= 1'b0;
      busy               <= 1'b0;
      res.result_valid   <= 1'b0;
      res.result_fine    <= '0;
      res.result_coarse  <= '0;
      res.result_timeout <= 1'b0;
      res.meas_id        <= '0;
    end else begin
      state            <= state_nxt;
      cntr_reset       <= (state_nxt == S_CLR);
      cntr_start       <= (state_nxt == S_FIRE);
      laser_fire       <= (state_nxt == S_FIRE);
      cntr_stop        <= (state_nxt == S_STOP);
      busy             <= (state_nxt != S_IDLE);
      res.result_valid <= (state_nxt == S_HOLD);

      if (state == S_IDLE) begin
        rst_cnt <= RC_W'(RST_CYCLES - 1);
      end else if (state == S_CLR && rst_cnt != '0) begin
        rst_cnt <= rst_cnt - 1'b1;
      end

      // A fresh echo edge outranks a timeout seen in the same cycle.
      if (state == S_IDLE) begin
        to_flag <= 1'b0;
      end else if (state == S_WAIT) begin
        if (rise) begin
          to_flag <= 1'b0;
        end else if (timeout_hit) begin
          to_flag <= 1'b1;
        end
      end

      if (state == S_SETTLE) begin
        res.result_fine    <= fine_cnt;
        res.result_coarse  <= coarse_cnt;
        res.result_timeout <= to_flag;
      end

      if (state == S_HOLD && res.result_ready) begin
        res.meas_id <= res.meas_id + 1'b1;
      end
    end
  end

endmodule
